// File: rtl/vending_pkg.sv
// Shared types and defaults for the vending dispatch controller.
// Holds the FSM state enum, parameter defaults and channel-width helper.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE,
    FAULT
  } state_t;

  localparam int MAX_TURNS_DEF = 9;
  localparam int TIMEOUT_DEF   = 50_000_000;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vm_sensor_sync.sv
// Two-flop synchroniser plus rising-edge detect for a sensor vector.
// Ports: clk, rst (sync, active-high), async_in[W], sync[W] level, rise[W] pulse.
module vm_sensor_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/vending_dispatch_ctrl.sv
// Multi-channel motor dispatch: one relay at a time, turn count, jam fault.
// Ports: clock/reset, valid/ready request, sensors, relay, status, turns left.
module vending_dispatch_ctrl
  import vending_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 4,
  parameter int MAX_TURNS   = MAX_TURNS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CH_W        = ch_w(N_CH)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [CH_W-1:0]  req_channel_in,
  input  logic [CNT_W-1:0] req_turns_in,
  input  logic [N_CH-1:0]  sensor1_in,
  input  logic [N_CH-1:0]  sensor2_in,
  input  logic             fault_clear_in,
  output logic [N_CH-1:0]  rele_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             reject_out,
  output logic             fault_out,
  output logic [CH_W-1:0]  fault_channel_out,
  output logic [CNT_W-1:0] turns_left_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CH_W-1:0]  ch_q;
  logic [TMR_W-1:0] timer;
  logic [N_CH-1:0]  s1_sync;
  logic [N_CH-1:0]  s1_rise;
  logic [N_CH-1:0]  s2_sync;
  logic [N_CH-1:0]  s2_rise;
  logic [N_CH-1:0]  one_hot;
  logic             bad_req;
  logic             unused_ok;

  vm_sensor_sync #(.W(N_CH)) u_sync1 (
    .clk      (clock_in),
    .rst      (reset_in),
    .async_in (sensor1_in),
    .sync     (s1_sync),
    .rise     (s1_rise)
  );

  vm_sensor_sync #(.W(N_CH)) u_sync2 (
    .clk      (clock_in),
    .rst      (reset_in),
    .async_in (sensor2_in),
    .sync     (s2_sync),
    .rise     (s2_rise)
  );

  assign unused_ok = ^{s1_sync, s2_rise};

  assign one_hot = N_CH'(1) << req_channel_in;
  assign bad_req = (req_turns_in == '0)
                || (int'(req_turns_in) > MAX_TURNS)
                || (int'(req_channel_in) >= N_CH);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state             <= IDLE;
      ch_q              <= '0;
      timer             <= '0;
      rele_out          <= '0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      reject_out        <= 1'b0;
      fault_out         <= 1'b0;
      fault_channel_out <= '0;
      turns_left_out    <= '0;
      req_ready_out     <= 1'b0;
    end else begin
      done_out   <= 1'b0;
      reject_out <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready_out <= 1'b1;
          if (req_valid_in && req_ready_out) begin
            if (bad_req) begin
              reject_out <= 1'b1;
            end else begin
              ch_q           <= req_channel_in;
              turns_left_out <= req_turns_in;
              timer          <= '0;
              rele_out       <= one_hot;
              busy_out       <= 1'b1;
              req_ready_out  <= 1'b0;
              state          <= RUN;
            end
          end
        end
        RUN: begin
          // A counted turn beats a timeout landing on the same cycle.
          if (s1_rise[ch_q]) begin
            timer <= '0;
            if (turns_left_out <= CNT_W'(1)) begin
              turns_left_out <= '0;
              rele_out       <= '0;
              state          <= SETTLE;
            end else begin
              turns_left_out <= turns_left_out - 1'b1;
            end
          end else if (timer == TMO_LAST) begin
            rele_out          <= '0;
            busy_out          <= 1'b0;
            fault_out         <= 1'b1;
            fault_channel_out <= ch_q;
            state             <= FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SETTLE: begin
          if (s2_sync[ch_q]) begin
            done_out      <= 1'b1;
            busy_out      <= 1'b0;
            req_ready_out <= 1'b1;
            state         <= IDLE;
          end else if (timer == TMO_LAST) begin
            busy_out          <= 1'b0;
            fault_out         <= 1'b1;
            fault_channel_out <= ch_q;
            state             <= FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FAULT: begin
          rele_out <= '0;
          if (fault_clear_in) begin
            fault_out      <= 1'b0;
            turns_left_out <= '0;
            req_ready_out  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_dispatch_ctrl.sv
// Directed bench for vending_dispatch_ctrl with short timeout.
// Drives requests and sensor pulses, checks outputs against fixed values.
module tb_vending_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       ready;
  logic [1:0] ch = '0;
  logic [3:0] turns = '0;
  logic [3:0] s1 = '0;
  logic [3:0] s2 = '0;
  logic       fclr = 1'b0;
  logic [3:0] rele;
  logic       busy;
  logic       done;
  logic       reject;
  logic       fault;
  logic [1:0] fault_ch;
  logic [3:0] left;

  int checks = 0;
  int failures = 0;
  int done_cnt;

  always #5 clk = ~clk;

  vending_dispatch_ctrl #(
    .N_CH        (4),
    .CNT_W       (4),
    .MAX_TURNS   (9),
    .TIMEOUT_CYC (100)
  ) dut (
    .clock_in          (clk),
    .reset_in          (rst),
    .req_valid_in      (valid),
    .req_ready_out     (ready),
    .req_channel_in    (ch),
    .req_turns_in      (turns),
    .sensor1_in        (s1),
    .sensor2_in        (s2),
    .fault_clear_in    (fclr),
    .rele_out          (rele),
    .busy_out          (busy),
    .done_out          (done),
    .reject_out        (reject),
    .fault_out         (fault),
    .fault_channel_out (fault_ch),
    .turns_left_out    (left)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] c, input logic [3:0] t);
    valid = 1'b1;
    ch    = c;
    turns = t;
    tick(1);
    valid = 1'b0;
  endtask

  task automatic pulse1(input int c);
    s1[c] = 1'b1;
    tick(2);
    s1[c] = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(3);
    check("rst_rele", 32'(rele), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fch", 32'(fault_ch), 32'h0);
    check("rst_left", 32'(left), 32'h0);
    rst = 1'b0;
    tick(1);
    check("rst_ready", 32'(ready), 32'h1);

    req(2'd2, 4'd3);
    check("t1_rele", 32'(rele), 32'h4);
    check("t1_left3", 32'(left), 32'd3);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_ready0", 32'(ready), 32'h0);
    pulse1(2);
    check("t1_left2", 32'(left), 32'd2);
    pulse1(2);
    check("t1_left1", 32'(left), 32'd1);
    check("t1_rele_run", 32'(rele), 32'h4);
    pulse1(2);
    check("t1_left0", 32'(left), 32'd0);
    check("t1_rele_off", 32'(rele), 32'h0);
    check("t1_settle_busy", 32'(busy), 32'h1);
    s2[2] = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (done) done_cnt++;
    end
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_ready1", 32'(ready), 32'h1);
    check("t1_idle_busy", 32'(busy), 32'h0);
    s2[2] = 1'b0;
    tick(4);

    req(2'd0, 4'd0);
    check("rej0_pulse", 32'(reject), 32'h1);
    check("rej0_rele", 32'(rele), 32'h0);
    tick(1);
    check("rej0_once", 32'(reject), 32'h0);
    req(2'd1, 4'd10);
    check("rej10_pulse", 32'(reject), 32'h1);
    check("rej10_rele", 32'(rele), 32'h0);
    check("rej10_ready", 32'(ready), 32'h1);
    tick(1);

    req(2'd1, 4'd2);
    check("t3_rele", 32'(rele), 32'h2);
    tick(99);
    check("t3_nofault99", 32'(fault), 32'h0);
    tick(1);
    check("t3_fault", 32'(fault), 32'h1);
    check("t3_fch", 32'(fault_ch), 32'd1);
    check("t3_rele0", 32'(rele), 32'h0);
    check("t3_frozen", 32'(left), 32'd2);
    check("t3_ready0", 32'(ready), 32'h0);
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    check("t3_clr_fault", 32'(fault), 32'h0);
    check("t3_clr_left", 32'(left), 32'd0);
    check("t3_clr_ready", 32'(ready), 32'h1);

    req(2'd0, 4'd2);
    valid = 1'b1;
    ch    = 2'd3;
    turns = 4'd1;
    pulse1(3);
    valid = 1'b0;
    check("t4_left", 32'(left), 32'd2);
    check("t4_ready", 32'(ready), 32'h0);
    check("t4_rele", 32'(rele), 32'h1);
    rst = 1'b1;
    tick(1);
    check("t4_rst_rele", 32'(rele), 32'h0);
    check("t4_rst_left", 32'(left), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(1);
    check("t4_rst_ready", 32'(ready), 32'h1);

    req(2'd3, 4'd1);
    tick(97);
    s1[3] = 1'b1;
    tick(2);
    s1[3] = 1'b0;
    tick(1);
    check("t5_nofault", 32'(fault), 32'h0);
    check("t5_left0", 32'(left), 32'd0);
    check("t5_settle", 32'(busy), 32'h1);
    check("t5_rele0", 32'(rele), 32'h0);
    tick(99);
    check("t5_settle_wait", 32'(fault), 32'h0);
    tick(1);
    check("t5_stuck_fault", 32'(fault), 32'h1);
    check("t5_stuck_fch", 32'(fault_ch), 32'd3);
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    check("t5_clr", 32'(ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
